flop_skid_capture: RTL and testbench
====================================

Name: flop_skid_capture

Overview:
- Receiving end of a registered flop-to-flop data path. It captures a launched word with a valid/ready handshake and re-presents it from a flop on the output side.
- A 2-entry skid buffer (main plus skid register) sustains one beat per clock under backpressure and keeps every handshake signal registered.
- Sits between an upstream launch stage and a downstream consumer. It also counts delivered beats for debug.

Parameters:
- WIDTH, 8, data bits per beat.
- CNT_W, 16, width of the delivered-beat counter.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat; registered.
- in_data  in  WIDTH  upstream beat data.
- out_valid  out  1  output beat valid; registered.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  WIDTH  output beat data; registered (main register).
- beat_cnt  out  CNT_W  count of output handshakes, wraps.

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: state=EMPTY, in_ready=0, out_valid=0, out_data=0, skid=0, beat_cnt=0.
- in_ready rises on the first posedge after rst_n deasserts.
- Accept event = in_valid & in_ready.
- Take event = out_valid & out_ready.
- States:
  - EMPTY: out_valid=0.
  - BUSY: main register holds one beat, out_valid=1.
  - FULL: main and skid both hold beats, out_valid=1.
- Transitions:
  - EMPTY, accept -> BUSY; main<=in_data.
  - BUSY, accept & take -> BUSY; main<=in_data.
  - BUSY, accept only -> FULL; skid<=in_data.
  - BUSY, take only -> EMPTY.
  - FULL, take -> BUSY; main<=skid. in_valid is ignored in FULL because in_ready=0.
  - No event -> hold state.
- in_ready register next value = (next_state != FULL). It is never combinationally dependent on out_ready.
- Latency: accepted beat appears on out_data/out_valid one cycle after acceptance when the block was EMPTY.
- Throughput: one beat per cycle while out_ready=1.
- Ordering: strict FIFO; no beat is dropped or duplicated.
- out_data is stable while out_valid=1 and out_ready=0.
- beat_cnt increments by 1 per take event, modulo 2^CNT_W. It wraps from all-ones to 0 silently.
- Reset mid-operation: all held beats are discarded immediately (async) and outputs return to reset values.

Optional Feature:
- Macro: FLOP_SKID_CAPTURE_PARITY_EN.
- With the macro defined:
  - Adds input in_par (1 bit, even parity over in_data) and output par_err (1 bit, registered).
  - Parity is checked on each accept event. A mismatch sets par_err on the next posedge.
  - par_err is sticky until rst_n; reset value 0.
  - Data flow is unaffected; the erroneous beat is still delivered.
- Without the macro: in_par and par_err ports and all parity logic are absent.

Decomposition:
- Package flop_skid_capture_pkg holds:
  - state enum {EMPTY, BUSY, FULL} (2 bits);
  - default WIDTH and CNT_W constants.
- No sub-module. State machine, two data registers and counter fit naturally in one module.

Test Plan:
- Reset: hold rst_n=0 mid-stream with FULL state -> out_valid=0, in_ready=0, beat_cnt=0 immediately. in_ready=1 one posedge after release.
- Streaming: in_valid=1 with data 0x01..0x10, out_ready=1 -> out_data 0x01..0x10 in order, one per cycle, first one cycle after accept. beat_cnt=16.
- Backpressure: send 0xA5 then 0x5A with out_ready=0 -> in_ready drops after 2nd accept (FULL). out_data holds 0xA5. Raising out_ready delivers 0xA5 then 0x5A, and in_ready returns to 1.
- Random valid/ready (10k beats, incrementing data) -> output sequence equals input sequence. No stall beyond FULL. beat_cnt = number of takes mod 2^CNT_W.
- Counter wrap: CNT_W=4, deliver 17 beats -> beat_cnt=1.
- Parity (macro on): send 0x03 with in_par=1 -> par_err=1 next cycle and stays 1. 0x03 is still delivered. Subsequent good beats do not clear par_err; rst_n clears it.

Source files
------------

// File: rtl/flop_skid_capture_pkg.sv
// Shared types and default sizing for the flop_skid_capture receive stage.
package flop_skid_capture_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/flop_skid_capture.sv
// Registered receive stage with a 2-entry skid buffer and a delivered-beat counter.
// Optional even-parity checking on accepted beats via `define FLOP_SKID_CAPTURE_PARITY_EN.
module flop_skid_capture
  import flop_skid_capture_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] beat_cnt
`ifdef FLOP_SKID_CAPTURE_PARITY_EN
  ,
  input  logic             in_par,
  output logic             par_err
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_s;
  logic             take_s;

  assign accept_s  = in_valid & in_ready_q;
  assign take_s    = out_valid_q & out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign beat_cnt  = cnt_q;

  // Next-state, data-register and counter logic.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept_s) begin
          state_d = BUSY;
          main_d  = in_data;
        end else begin
          state_d = EMPTY;
        end
      end
      BUSY: begin
        if (accept_s && take_s) begin
          state_d = BUSY;
          main_d  = in_data;
        end else if (accept_s) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (take_s) begin
          state_d = EMPTY;
        end else begin
          state_d = BUSY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain path is possible.
        if (take_s) begin
          state_d = BUSY;
          main_d  = skid_q;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (take_s) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  // State, handshake, data and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      main_q      <= {WIDTH{1'b0}};
      skid_q      <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef FLOP_SKID_CAPTURE_PARITY_EN
  logic par_err_q, par_err_d;

  // Even parity: the parity bit equals the XOR of all data bits.
  function automatic logic par_mismatch(input logic [WIDTH-1:0] data, input logic par);
    return (^data) ^ par;
  endfunction

  // Sticky parity error flag, set on any accepted beat with bad parity.
  always_comb begin
    if (accept_s && par_mismatch(in_data, in_par)) begin
      par_err_d = 1'b1;
    end else begin
      par_err_d = par_err_q;
    end
  end

  // Parity error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_flop_skid_capture.sv
// Scoreboard bench for flop_skid_capture: driver pushes accepted beats, monitor pops on takes.
module tb_flop_skid_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data, out_data;
  logic [15:0] beat_cnt;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [7:0]  in_data4, out_data4;
  logic [3:0]  beat_cnt4;

`ifdef FLOP_SKID_CAPTURE_PARITY_EN
  logic in_par, par_err, in_par4, par_err4;
  logic par_flip = 1'b0;
`endif

  always #5 clk = ~clk;

  flop_skid_capture u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .beat_cnt(beat_cnt)
`ifdef FLOP_SKID_CAPTURE_PARITY_EN
    , .in_par(in_par), .par_err(par_err)
`endif
  );

  flop_skid_capture #(.WIDTH(8), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .beat_cnt(beat_cnt4)
`ifdef FLOP_SKID_CAPTURE_PARITY_EN
    , .in_par(in_par4), .par_err(par_err4)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int          occ = 0;
  logic        model_ready = 1'b0;
  logic [15:0] take_cnt = 16'd0;
  logic        mon_acc, mon_tk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: occupancy model for handshakes, scoreboard pop on every take.
  always @(negedge clk) begin
    if (!rst_n) begin
      occ = 0;
      model_ready = 1'b0;
      take_cnt = 16'd0;
      exp_q.delete();
    end else begin
      check("mon_in_ready", 32'(in_ready), 32'(model_ready));
      check("mon_out_valid", 32'(out_valid), 32'(occ != 0));
      check("mon_beat_cnt", 32'(beat_cnt), 32'(take_cnt));
      mon_acc = in_valid & model_ready;
      mon_tk  = (occ != 0) & out_ready;
      if (mon_tk) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        take_cnt = take_cnt + 16'd1;
      end
      occ = occ + (mon_acc ? 1 : 0) - (mon_tk ? 1 : 0);
      model_ready = (occ != 2);
    end
  end

  // One clock of stimulus; returns whether the beat was accepted.
  task automatic drive(input logic v, input logic [7:0] d, input logic r, output logic acc);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
`ifdef FLOP_SKID_CAPTURE_PARITY_EN
    in_par = (^d) ^ par_flip;
`endif
    @(negedge clk);
    acc = rst_n && v && in_ready;
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  logic       acc;
  logic [7:0] rdata;
  int         beats, cyc;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    in_valid4 = 1'b0; in_data4 = 8'h00; out_ready4 = 1'b0;
`ifdef FLOP_SKID_CAPTURE_PARITY_EN
    in_par = 1'b0; in_par4 = 1'b0;
`endif
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("ready_after_release", 32'(in_ready), 32'd1);

    // Streaming 0x01..0x10 with the consumer always ready.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 8'(i), 1'b1, acc);
      if (i == 1) begin
        check("latency_valid", 32'(out_valid), 32'd1);
        check("latency_data", 32'(out_data), 32'h01);
      end
    end
    repeat (3) drive(1'b0, 8'h00, 1'b1, acc);
    check("stream_cnt", 32'(beat_cnt), 32'd16);

    // Backpressure: fill both registers, then drain.
    drive(1'b1, 8'hA5, 1'b0, acc);
    drive(1'b1, 8'h5A, 1'b0, acc);
    check("bp_full_ready", 32'(in_ready), 32'd0);
    check("bp_hold_data", 32'(out_data), 32'hA5);
    drive(1'b1, 8'h77, 1'b0, acc);
    check("bp_ignored", 32'(acc), 32'd0);
    drive(1'b0, 8'h00, 1'b0, acc);
    check("bp_stable", 32'(out_data), 32'hA5);
    drive(1'b0, 8'h00, 1'b1, acc);
    check("bp_ready_back", 32'(in_ready), 32'd1);
    check("bp_second", 32'(out_data), 32'h5A);
    drive(1'b0, 8'h00, 1'b1, acc);
    check("bp_empty", 32'(out_valid), 32'd0);
    check("bp_cnt", 32'(beat_cnt), 32'd18);

    // Asynchronous reset while FULL.
    drive(1'b1, 8'h11, 1'b0, acc);
    drive(1'b1, 8'h22, 1'b0, acc);
    check("pre_rst_full", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_beat_cnt", 32'(beat_cnt), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("midrst_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("midrst_ready_up", 32'(in_ready), 32'd1);

    // Random valid/ready with incrementing data.
    rdata = 8'h00; beats = 0; cyc = 0;
    while (beats < 10000 && cyc < 60000) begin
      drive(1'($urandom_range(0, 3) != 0), rdata, 1'($urandom_range(0, 3) != 0), acc);
      if (acc) begin
        rdata = rdata + 8'd1;
        beats++;
      end
      cyc++;
    end
    check("rand_budget", 32'(beats), 32'd10000);
    cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 10) begin
      drive(1'b0, 8'h00, 1'b1, acc);
      cyc++;
    end
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_cnt", 32'(beat_cnt), 32'd10000);

    // Counter wrap on a 4-bit counter instance.
    for (int i = 0; i < 17; i++) begin
      in_valid4 = 1'b1; in_data4 = 8'(i); out_ready4 = 1'b1;
`ifdef FLOP_SKID_CAPTURE_PARITY_EN
      in_par4 = ^in_data4;
`endif
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("wrap_cnt", 32'(beat_cnt4), 32'd1);

`ifdef FLOP_SKID_CAPTURE_PARITY_EN
    check("par_clear", 32'(par_err), 32'd0);
    par_flip = 1'b1;
    drive(1'b1, 8'h03, 1'b1, acc);
    par_flip = 1'b0;
    check("par_set", 32'(par_err), 32'd1);
    drive(1'b1, 8'h04, 1'b1, acc);
    drive(1'b1, 8'h05, 1'b1, acc);
    drive(1'b0, 8'h00, 1'b1, acc);
    check("par_sticky", 32'(par_err), 32'd1);
    rst_n = 1'b0;
    #1;
    check("par_rst", 32'(par_err), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
